// File: rtl/pair_select_sort_buf.sv
// Operand pair selector with pass/swap/sort modes, feeding a DEPTH-entry
// output FIFO with valid/ready on both sides and a saturating exchange counter.
module pair_select_sort_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             sel,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] swap_cnt,
  output logic [OCC_W-1:0] count
);

  logic [WIDTH-1:0] mem_1 [DEPTH];
  logic [WIDTH-1:0] mem_2 [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] res_1;
  logic [WIDTH-1:0] res_2;
  logic             xchg;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] count_nxt;
  logic [WIDTH-1:0] head_1_nxt;
  logic [WIDTH-1:0] head_2_nxt;

  assign p          = sel ? b : a;
  assign q          = sel ? c : d;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // Mode decode; equal operands never count as an exchange.
  always_comb begin
    res_1 = p;
    res_2 = q;
    xchg  = 1'b0;
    case (mode)
      2'b01: begin
        res_1 = q;
        res_2 = p;
        xchg  = 1'b1;
      end
      2'b10: begin
        if (p > q) begin
          res_1 = q;
          res_2 = p;
          xchg  = 1'b1;
        end
      end
      2'b11: begin
        if (p < q) begin
          res_1 = q;
          res_2 = p;
          xchg  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and the value the head registers take after this edge.
  always_comb begin
    count_nxt  = count;
    head_1_nxt = out_1;
    head_2_nxt = out_2;
    case ({push, pop})
      2'b10:   count_nxt = count + OCC_W'(1);
      2'b01:   count_nxt = count - OCC_W'(1);
      default: count_nxt = count;
    endcase
    if (pop) begin
      if (count > OCC_W'(1)) begin
        head_1_nxt = mem_1[rd_ptr_inc];
        head_2_nxt = mem_2[rd_ptr_inc];
      end else if (push) begin
        head_1_nxt = res_1;
        head_2_nxt = res_2;
      end
    end else if (push && (count == OCC_W'(0))) begin
      head_1_nxt = res_1;
      head_2_nxt = res_2;
    end
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_1[wr_ptr] <= res_1;
      mem_2[wr_ptr] <= res_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_1     <= '0;
      out_2     <= '0;
      swap_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count     <= count_nxt;
      out_valid <= (count_nxt != OCC_W'(0));
      in_ready  <= (count_nxt < OCC_W'(DEPTH));
      out_1     <= head_1_nxt;
      out_2     <= head_2_nxt;
      if (push && xchg && (swap_cnt != {CNT_W{1'b1}}))
        swap_cnt <= swap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pair_select_sort_buf.md
Name: pair_select_sort_buf

Overview:
- Parametrised successor to the 8-bit two-output pair selector.
- Selects one operand pair from four WIDTH-bit inputs:
  - sel=0 picks (a,d).
  - sel=1 picks (b,c).
- Applies a per-transaction mode: pass, swap, ascending order or descending order.
- Buffers results in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Keeps a saturating count of transactions whose pair order was exchanged. Sits between operand generation and the downstream compare/sort datapath.

Parameters:
- WIDTH, 8, bit width of each operand and each output.
- DEPTH, 4, output FIFO entries (power of two, >=2).
- CNT_W, 8, width of swap counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- d  input  WIDTH  operand D.
- sel  input  1  pair select: 0=(a,d), 1=(b,c).
- mode  input  2  00 pass, 01 swap, 10 ascending, 11 descending.
- in_valid  input  1  operands/sel/mode valid.
- in_ready  output  1  block can accept this cycle.
- out_1  output  WIDTH  first result of head FIFO entry.
- out_2  output  WIDTH  second result of head FIFO entry.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- swap_cnt  output  CNT_W  saturating count of exchanged transactions.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert on clk edge): FIFO empty, count=0, out_valid=0, out_1=out_2=0, swap_cnt=0, in_ready=1.
- Pair: (p,q) = sel ? (b,c) : (a,d).
- Result per mode:
  - 00: (p,q).
  - 01: (q,p).
  - 10: (min,max), unsigned compare.
  - 11: (max,min), unsigned compare.
  - Equal operands in modes 10/11 give (p,q), with no exchange.
- Exchange flag: set when result order differs from (p,q):
  - always in mode 01;
  - in mode 10 when p>q;
  - in mode 11 when p<q.
- Push: in_valid && in_ready at a rising edge writes the result into the tail entry.
- Latency: the result is visible on out_1/out_2 with out_valid=1 on the cycle after the push, if the FIFO was empty. There is no combinational input-to-output path.
- in_ready = (count < DEPTH). It depends only on registered state and not on out_ready. A full FIFO rejects input even when a pop happens in the same cycle.
- Pop: out_valid && out_ready at an edge advances the head.
- out_1/out_2 always show the head entry and hold stable while out_valid && !out_ready.
- When empty, out_1/out_2 hold the last popped values (0 after reset).
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is updated by +1 on push only, -1 on pop only, 0 otherwise.
- swap_cnt increments by 1 on each accepted push with the exchange flag set. It saturates at 2^CNT_W-1 and does not wrap. It clears only on reset.
- in_valid without in_ready: no state change. The source must hold its data stable.
- Reset mid-operation discards all FIFO contents immediately. There is no partial output.

Test Plan:
- Reset, then push a=8'h11, d=8'h44, sel=0, mode=00 -> next cycle out_1=8'h11, out_2=8'h44, out_valid=1, swap_cnt=0.
- Push b=8'h22, c=8'h33, sel=1, mode=01 -> out_1=8'h33, out_2=8'h22, swap_cnt=1.
- Modes 10/11:
  - mode=10, a=8'hF0, d=8'h0F, sel=0 -> (8'h0F, 8'hF0), swap_cnt+1.
  - mode=11, same operands -> (8'hF0, 8'h0F), no increment.
  - mode=10 with a=d=8'h55 -> (8'h55, 8'h55), no increment.
- Hold out_ready=0 and push 4 entries -> count=4, in_ready=0.
  - A 5th in_valid is ignored.
  - out_1/out_2 remain on entry 0.
  - Release out_ready -> entries drain in order, one per cycle.
  - Wrap: push/pop concurrently for 10 transactions -> order preserved across pointer wrap, count constant.
- Saturation and reset: with CNT_W=2, make 5 swap transactions -> swap_cnt=3.
  - Assert rst_n=0 asynchronously with 2 entries queued -> out_valid=0, count=0, swap_cnt=0 before the next clk edge.
